fft_io_sequencer: RTL and testbench
===================================

FFT_IO_SEQUENCER -- requirements
Module: fft_io_sequencer

Interface
REQ-001 Parameter ADDR_W, default 10, meaning sample-memory address width; frame length N = 2**ADDR_W.
REQ-002 Parameter DATA_W, default 16, meaning sample width.
REQ-003 Parameter BIT_REVERSE, default 1, meaning 1 = read-out in bit-reversed address order, 0 = natural order.
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 go  in  1  start one frame; sampled only in IDLE.
REQ-008 in_valid  in  1  / in_data  in  DATA_W  / in_ready  out  1  sample load stream.
REQ-009 out_valid  out  1  / out_data  out  DATA_W  / out_ready  in  1  sample read-out stream to FFT core.
REQ-010 mem_read_enable, mem_write_enable, mem_start_write, mem_end_write  out  1 each  memory control.
REQ-011 mem_address  out  ADDR_W  / mem_wdata  out  DATA_W  / mem_rdata  in  DATA_W  memory port.
REQ-012 busy  out  1  high in every state except IDLE; done  out  1  one-cycle end-of-frame pulse.

Function
REQ-013 FSM states SHALL be IDLE, START, LOAD, CLOSE, RD_ISSUE, RD_WAIT, RD_OUT, DONE.
REQ-014 IDLE: go=1 -> START; go ignored in all other states.
REQ-015 START: mem_start_write=1 for exactly one cycle; write counter wcnt cleared; -> LOAD.
REQ-016 LOAD: in_ready=1; on in_valid&in_ready, mem_write_enable=1, mem_address=wcnt, mem_wdata=in_data same cycle (combinational pass-through), wcnt increments.
REQ-017 LOAD: handshake at wcnt=N-1 -> CLOSE; in_valid=0 cycles stall without writes.
REQ-018 CLOSE: mem_end_write=1 for exactly one cycle, in_ready=0; read counter rcnt cleared; -> RD_ISSUE.
REQ-019 RD_ISSUE: mem_read_enable=1, mem_address=bitrev(rcnt) if BIT_REVERSE else rcnt; -> RD_WAIT.
REQ-020 Memory read latency SHALL be one cycle: mem_rdata valid in the cycle after mem_read_enable.
REQ-021 RD_WAIT: mem_rdata captured into out_data register; -> RD_OUT.
REQ-022 RD_OUT: out_valid=1, out_data stable until out_ready=1; on handshake: rcnt=N-1 -> DONE, else rcnt++ -> RD_ISSUE.
REQ-023 DONE: done=1 one cycle; -> IDLE.
REQ-024 mem_read_enable and mem_write_enable SHALL never be high in the same cycle; start/end pulses never coincide with read or write enables.
REQ-025 Counters SHALL be ADDR_W bits; no wrap beyond N-1 occurs because terminal count changes state.
REQ-026 Read-out throughput SHALL be one sample per three cycles with out_ready held high.
REQ-027 Unused outputs SHALL be 0 (mem_address, mem_wdata 0 outside active write/read cycles).

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, wcnt=rcnt=0, out_data=0, all outputs 0.
REQ-029 rst mid-frame SHALL abort without issuing mem_end_write; memory contents are not cleared; next frame requires a new go.

Structure
REQ-030 Package fft_io_pkg SHALL hold the state enum typedef and default ADDR_W, DATA_W constants.
REQ-031 Sub-module bit_reverse (combinational, parameter WIDTH) SHALL produce the reversed read address.

Verification (ADDR_W=3, N=8)
REQ-032 Load 8..F with in_valid held high -> mem_start_write one cycle before first write; writes addr 0..7 data 8..F in 8 consecutive cycles; mem_end_write next cycle.
REQ-033 Read-out with BIT_REVERSE=1, out_ready=1 -> addresses 0,4,2,6,1,5,3,7; out_data 8,C,A,E,9,D,B,F; done pulses once; busy falls after it.
REQ-034 BIT_REVERSE=0 -> out_data 8..F in order.
REQ-035 out_ready low 5 cycles during RD_OUT -> out_valid and out_data held, no extra mem_read_enable.
REQ-036 rst asserted after 4th write -> all outputs 0 immediately, no mem_end_write; go after release restarts at address 0.
REQ-037 go pulsed during LOAD and RD_OUT -> ignored; exactly one frame and one done pulse.

Source files
------------

// File: rtl/fft_io_pkg.sv
// rtl/fft_io_pkg.sv - shared state encoding and default widths for the FFT I/O sequencer
package fft_io_pkg;
  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD,
    CLOSE,
    RD_ISSUE,
    RD_WAIT,
    RD_OUT,
    DONE
  } state_t;
endpackage

// File: rtl/bit_reverse.sv
// rtl/bit_reverse.sv - combinational bit-order reversal of a read index
module bit_reverse #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] in_bits,
  output logic [WIDTH-1:0] out_bits
);
  always_comb begin
    out_bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_bits[i] = in_bits[WIDTH-1-i];
    end
  end
endmodule

// File: rtl/fft_io_sequencer.sv
// rtl/fft_io_sequencer.sv - loads one frame into sample memory, then streams it out
// in natural or bit-reversed order, one sample per three cycles.
module fft_io_sequencer
  import fft_io_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic              mem_start_write,
  output logic              mem_end_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W-1:0] ONE  = 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] rev_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_fire;

  bit_reverse #(.WIDTH(ADDR_W)) u_bit_reverse (
    .in_bits (rcnt_q),
    .out_bits(rev_addr)
  );

  assign rd_addr = BIT_REVERSE ? rev_addr : rcnt_q;
  assign wr_fire = (state_q == LOAD) && in_valid;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE:     if (go) state_d = START;
      START: begin
        wcnt_d  = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (in_valid) begin
          wcnt_d = wcnt_q + ONE;
          if (wcnt_q == LAST) state_d = CLOSE;
        end
      end
      CLOSE: begin
        rcnt_d  = '0;
        state_d = RD_ISSUE;
      end
      RD_ISSUE: state_d = RD_WAIT;
      // Memory returns data one cycle after the read strobe.
      RD_WAIT: begin
        out_data_d = mem_rdata;
        state_d    = RD_OUT;
      end
      RD_OUT: begin
        if (out_ready) begin
          if (rcnt_q == LAST) begin
            state_d = DONE;
          end else begin
            rcnt_d  = rcnt_q + ONE;
            state_d = RD_ISSUE;
          end
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign in_ready         = (state_q == LOAD);
  assign out_valid        = (state_q == RD_OUT);
  assign out_data         = out_data_q;
  assign mem_start_write  = (state_q == START);
  assign mem_end_write    = (state_q == CLOSE);
  assign mem_read_enable  = (state_q == RD_ISSUE);
  assign mem_write_enable = wr_fire;
  // Address and write data stay at zero outside an actual access.
  assign mem_address      = wr_fire ? wcnt_q : ((state_q == RD_ISSUE) ? rd_addr : '0);
  assign mem_wdata        = wr_fire ? in_data : '0;
endmodule

// File: tb/tb_fft_io_sequencer.sv
// tb/tb_fft_io_sequencer.sv - bench running bit-reversed and natural-order instances in lockstep
module tb_fft_io_sequencer;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int N  = 8;

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [AW-1:0] ab;   logic [AW-1:0] an;   } rd_t;
  typedef struct packed { logic [DW-1:0] db;   logic [DW-1:0] dn;   } od_t;

  logic clk = 1'b0;
  logic rst, go, in_valid, out_ready;
  logic [DW-1:0] in_data;

  logic in_ready_b, out_valid_b, re_b, we_b, sw_b, ew_b, busy_b, done_b;
  logic [DW-1:0] out_data_b, wdata_b, rdata_b;
  logic [AW-1:0] addr_b;
  logic in_ready_n, out_valid_n, re_n, we_n, sw_n, ew_n, busy_n, done_n;
  logic [DW-1:0] out_data_n, wdata_n, rdata_n;
  logic [AW-1:0] addr_n;

  logic [DW-1:0] mem_b [N];
  logic [DW-1:0] mem_n [N];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  wr_t exp_w[$];
  rd_t exp_r[$];
  od_t exp_o[$];
  int  t_start[$], t_wr[$], t_end[$], t_rd[$], t_out[$], t_done[$];
  logic [AW-1:0] obs_ra_b[$];
  logic [DW-1:0] obs_out_b[$], obs_out_n[$];

  always #5 clk = ~clk;

  fft_io_sequencer #(.ADDR_W(AW), .DATA_W(DW), .BIT_REVERSE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .go(go),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready),
    .mem_read_enable(re_b), .mem_write_enable(we_b),
    .mem_start_write(sw_b), .mem_end_write(ew_b),
    .mem_address(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
    .busy(busy_b), .done(done_b)
  );

  fft_io_sequencer #(.ADDR_W(AW), .DATA_W(DW), .BIT_REVERSE(1'b0)) dut_n (
    .clk(clk), .rst(rst), .go(go),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_n),
    .out_valid(out_valid_n), .out_data(out_data_n), .out_ready(out_ready),
    .mem_read_enable(re_n), .mem_write_enable(we_n),
    .mem_start_write(sw_n), .mem_end_write(ew_n),
    .mem_address(addr_n), .mem_wdata(wdata_n), .mem_rdata(rdata_n),
    .busy(busy_n), .done(done_n)
  );

  // One-cycle-latency sample memories; contents survive reset.
  always @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= wdata_b;
    if (re_b) rdata_b <= mem_b[addr_b];
    if (we_n) mem_n[addr_n] <= wdata_n;
    if (re_n) rdata_n <= mem_n[addr_n];
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int rev_model(input int i);
    int r = 0;
    int v = i;
    for (int b = 0; b < AW; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic void load_expect(input logic [DW-1:0] base);
    int r;
    exp_w.delete(); exp_r.delete(); exp_o.delete();
    for (int i = 0; i < N; i++) begin
      r = rev_model(i);
      exp_w.push_back('{addr: AW'(i), data: base + DW'(i)});
      exp_r.push_back('{ab: AW'(r), an: AW'(i)});
      exp_o.push_back('{db: base + DW'(r), dn: base + DW'(i)});
    end
  endfunction

  function automatic void clear_events();
    t_start.delete(); t_wr.delete(); t_end.delete();
    t_rd.delete(); t_out.delete(); t_done.delete();
    obs_ra_b.delete(); obs_out_b.delete(); obs_out_n.delete();
  endfunction

  function automatic void check_all_zero(input string tag);
    check({tag, "_ctrl"}, {busy_b, done_b, in_ready_b, out_valid_b, re_b, we_b, sw_b, ew_b,
                           busy_n, done_n, in_ready_n, out_valid_n, re_n, we_n, sw_n, ew_n}, 0);
    check({tag, "_addr"}, {addr_b, addr_n}, 0);
    check({tag, "_wdata"}, {wdata_b, wdata_n}, 0);
    check({tag, "_out_data"}, {out_data_b, out_data_n}, 0);
  endfunction

  // Scoreboard and protocol checks on every cycle.
  always @(negedge clk) begin
    wr_t ew;
    rd_t er;
    od_t eo;
    cyc++;
    check("rw_exclusive", {re_b & we_b, re_n & we_n}, 0);
    check("pulse_exclusive", {(sw_b | ew_b) & (re_b | we_b), (sw_n | ew_n) & (re_n | we_n)}, 0);
    if (!re_b && !we_b) check("addr_idle_zero_b", addr_b, 0);
    if (!re_n && !we_n) check("addr_idle_zero_n", addr_n, 0);
    if (!we_b || !we_n) check("wdata_idle_zero", {we_b ? 16'h0 : wdata_b, we_n ? 16'h0 : wdata_n}, 0);
    if (sw_b) t_start.push_back(cyc);
    if (ew_b || ew_n) begin
      check("end_lockstep", ew_n, ew_b);
      t_end.push_back(cyc);
    end
    if (done_b) t_done.push_back(cyc);
    if (we_b || we_n) begin
      check("we_lockstep", we_n, we_b);
      t_wr.push_back(cyc);
      if (exp_w.size() == 0) check("unexpected_write", 1, 0);
      else begin
        ew = exp_w.pop_front();
        check("wr_addr_b", addr_b, ew.addr);
        check("wr_data_b", wdata_b, ew.data);
        check("wr_addr_n", addr_n, ew.addr);
        check("wr_data_n", wdata_n, ew.data);
      end
    end
    if (re_b || re_n) begin
      check("re_lockstep", re_n, re_b);
      t_rd.push_back(cyc);
      obs_ra_b.push_back(addr_b);
      if (exp_r.size() == 0) check("unexpected_read", 1, 0);
      else begin
        er = exp_r.pop_front();
        check("rd_addr_b", addr_b, er.ab);
        check("rd_addr_n", addr_n, er.an);
      end
    end
    if ((out_valid_b || out_valid_n) && out_ready) begin
      check("out_valid_lockstep", out_valid_n, out_valid_b);
      t_out.push_back(cyc);
      obs_out_b.push_back(out_data_b);
      obs_out_n.push_back(out_data_n);
      if (exp_o.size() == 0) check("unexpected_output", 1, 0);
      else begin
        eo = exp_o.pop_front();
        check("out_data_b", out_data_b, eo.db);
        check("out_data_n", out_data_n, eo.dn);
      end
    end
  end

  task automatic run_frame(input logic [DW-1:0] base, input bit gaps, input bit stall, input bit spam);
    int guard = 0;
    int stall_left = 0;
    int rd_before = 0;
    bit stalled = 0;
    bit got_done = 0;
    logic [DW-1:0] held_b = '0;
    logic [DW-1:0] held_n = '0;
    clear_events();
    load_expect(base);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    while (!got_done && guard < 300) begin
      guard++;
      in_valid  = in_ready_b && (t_wr.size() < N) && !(gaps && (guard % 3 == 0));
      in_data   = base + DW'(t_wr.size());
      go        = spam && ((in_ready_b && t_wr.size() == 3) || (out_valid_b && t_out.size() == 2));
      out_ready = 1'b1;
      if (stall && !stalled && out_valid_b && t_out.size() == 4) begin
        stalled    = 1'b1;
        stall_left = 5;
        held_b     = out_data_b;
        held_n     = out_data_n;
        rd_before  = t_rd.size();
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
      @(negedge clk);
      if (!out_ready) begin
        check("stall_valid_held", {out_valid_b, out_valid_n}, 2'b11);
        check("stall_data_held_b", out_data_b, held_b);
        check("stall_data_held_n", out_data_n, held_n);
        if (stall_left == 0) check("stall_no_extra_read", t_rd.size(), rd_before);
      end
      if (done_b) got_done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    go        = 1'b0;
    out_ready = 1'b1;
    check("frame_done_seen", got_done, 1);
    @(negedge clk);
    check("busy_low_after_done", busy_b | busy_n, 0);
    check("done_one_cycle", done_b | done_n, 0);
    check("start_pulse_count", t_start.size(), 1);
    check("write_count", t_wr.size(), N);
    check("end_pulse_count", t_end.size(), 1);
    check("read_count", t_rd.size(), N);
    check("output_count", t_out.size(), N);
    check("done_pulse_count", t_done.size(), 1);
    check("expect_drained", exp_w.size() + exp_r.size() + exp_o.size(), 0);
    if (t_start.size() == 1 && t_wr.size() == N && t_end.size() == 1) begin
      check("start_before_first_write", t_wr[0] - t_start[0], 1);
      check("end_after_last_write", t_end[0] - t_wr[N-1], 1);
      if (!gaps) check("writes_consecutive", t_wr[N-1] - t_wr[0], N - 1);
    end
    if (t_end.size() == 1 && t_rd.size() == N) check("first_read_after_end", t_rd[0] - t_end[0], 1);
    if (t_out.size() == N && t_done.size() == 1) begin
      check("done_after_last_output", t_done[0] - t_out[N-1], 1);
      if (!stall)
        for (int i = 0; i < N - 1; i++) check("readout_every_3", t_out[i+1] - t_out[i], 3);
    end
  endtask

  task automatic abort_frame(input logic [DW-1:0] base);
    int guard = 0;
    clear_events();
    load_expect(base);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    while (t_wr.size() < 4 && guard < 100) begin
      guard++;
      in_valid = in_ready_b;
      in_data  = base + DW'(t_wr.size());
      @(negedge clk);
      if (t_wr.size() < 4) begin
        @(posedge clk); #1;
      end
    end
    check("abort_reached_4th_write", t_wr.size(), 4);
    #1 rst = 1'b1;
    #1 check_all_zero("abort_reset");
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_w.delete(); exp_r.delete(); exp_o.delete();
    repeat (3) @(negedge clk);
    check("abort_no_end_write", t_end.size(), 0);
    check("abort_write_count", t_wr.size(), 4);
    check("abort_stays_idle", busy_b | busy_n, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [AW-1:0] lit_ra  [N] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    logic [DW-1:0] lit_ob  [N] = '{16'h8, 16'hC, 16'hA, 16'hE, 16'h9, 16'hD, 16'hB, 16'hF};
    rst = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(16'h0008, 1'b0, 1'b0, 1'b0);
    check("lit_read_addr_count", obs_ra_b.size(), N);
    check("lit_out_count", obs_out_b.size(), N);
    if (obs_ra_b.size() == N && obs_out_b.size() == N && obs_out_n.size() == N) begin
      for (int i = 0; i < N; i++) begin
        check("lit_bitrev_addr", obs_ra_b[i], lit_ra[i]);
        check("lit_bitrev_data", obs_out_b[i], lit_ob[i]);
        check("lit_natural_data", obs_out_n[i], 16'h8 + 16'(i));
      end
    end

    run_frame(16'h0020, 1'b1, 1'b1, 1'b1);
    abort_frame(16'h0030);
    run_frame(16'h0040, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end
endmodule
